// File: rtl/bus_lane_arbiter.sv
// Round-robin arbiter that grants one of NREQ requesters onto a shared,
// registered WIDTH-bit bus lane. A held word waits for bus_ready before it is released.
module bus_lane_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      bus_data,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [SW-1:0]         bus_src,
    output logic [7:0]            xfer_cnt
);

    localparam int unsigned LAST = NREQ - 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    src_q, src_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [SW-1:0]    sel;
    logic             found;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] lane_word;

    // Two-pass scan: indices at or above ptr first, then the wrapped-around low indices.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr_q))) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < 32'(ptr_q))) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
    end

    always_comb begin
        lane_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (SW'(i) == sel) begin
                lane_word = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state_q == FULL) && bus_ready;
    // rst_n gates load so that gnt stays low for the whole time reset is asserted.
    assign load   = rst_n && found && ((state_q == EMPTY) || bus_ready);

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt[i] = load && (SW'(i) == sel);
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (load) begin
            state_d = FULL;
            data_d  = lane_word;
            src_d   = sel;
            ptr_d   = (32'(sel) == LAST) ? '0 : sel + 1'b1;
        end else if (accept) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_valid = (state_q == FULL);
    assign bus_data  = data_q;
    assign bus_src   = src_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_bus_lane_arbiter.sv
// Directed bench for bus_lane_arbiter: reset, single grant, round-robin,
// backpressure, pointer wrap/skip and transfer-counter wrap.
module tb_bus_lane_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data_in;
    logic [3:0]  gnt;
    logic [3:0]  bus_data;
    logic        bus_valid;
    logic        bus_ready;
    logic [1:0]  bus_src;
    logic [7:0]  xfer_cnt;

    int checks;
    int failures;

    bus_lane_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_src   (bus_src),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'($urandom);
        data_in   = 16'($urandom);
        bus_ready = 1'($urandom);
        #2;
        repeat (2) begin
            tick();
            req     = 4'($urandom) | 4'b0001;
            data_in = 16'($urandom);
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                failures++;
                $display("FAIL reset_gnt: got %b want 0000", gnt);
            end
            checks++;
            if (bus_valid !== 1'b0 || bus_data !== 4'h0 || bus_src !== 2'd0) begin
                failures++;
                $display("FAIL reset_lane: got valid=%b data=%h src=%0d want 0/0/0",
                         bus_valid, bus_data, bus_src);
            end
            checks++;
            if (xfer_cnt !== 8'd0) begin
                failures++;
                $display("FAIL reset_cnt: got %0d want 0", xfer_cnt);
            end
        end
        req   = 4'b0000;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req       = 4'b0100;
        data_in   = 16'h0A00;
        bus_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL single_gnt: got %b want 0100", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (bus_data !== 4'hA || bus_valid !== 1'b1 || bus_src !== 2'd2) begin
            failures++;
            $display("FAIL single_lane: got data=%h valid=%b src=%0d want A/1/2",
                     bus_data, bus_valid, bus_src);
        end
        checks++;
        if (xfer_cnt !== 8'd0) begin
            failures++;
            $display("FAIL single_cnt0: got %0d want 0", xfer_cnt);
        end
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL single_nogrant: got %b want 0000", gnt);
        end
        tick();
        checks++;
        if (xfer_cnt !== 8'd1 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got cnt=%0d valid=%b want 1/0", xfer_cnt, bus_valid);
        end
    endtask

    task automatic test_reset_mid();
        // ptr is 3 here, so requester 0 is found after wrapping
        req       = 4'b0001;
        data_in   = 16'h0005;
        bus_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL mid_gnt: got %b want 0001", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== 4'h5) begin
            failures++;
            $display("FAIL mid_full: got valid=%b data=%h want 1/5", bus_valid, bus_data);
        end
        #2;
        rst_n     = 1'b0;
        bus_ready = 1'b1;
        req       = 4'b1111;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || bus_data !== 4'h0 || bus_src !== 2'd0 || xfer_cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_clear: got valid=%b data=%h src=%0d cnt=%0d want 0/0/0/0",
                     bus_valid, bus_data, bus_src, xfer_cnt);
        end
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL mid_gnt_rst: got %b want 0000", gnt);
        end
        req = 4'b0000;
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (xfer_cnt !== 8'd0 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after: got cnt=%0d valid=%b want 0/0", xfer_cnt, bus_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_src [5] = '{0, 1, 2, 3, 0};
        int exp_dat [5] = '{1, 2, 3, 4, 1};
        logic [3:0] exp_gnt;
        req       = 4'b1111;
        data_in   = 16'h4321;
        bus_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_gnt = 4'b0001 << exp_src[k];
            checks++;
            if (gnt !== exp_gnt) begin
                failures++;
                $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt);
            end
            tick();
            checks++;
            if (bus_valid !== 1'b1 || 32'(bus_src) != exp_src[k] || 32'(bus_data) != exp_dat[k]) begin
                failures++;
                $display("FAIL rr_lane[%0d]: got valid=%b src=%0d data=%h want 1/%0d/%0h",
                         k, bus_valid, bus_src, bus_data, exp_src[k], exp_dat[k]);
            end
            checks++;
            if (32'(xfer_cnt) != k) begin
                failures++;
                $display("FAIL rr_cnt[%0d]: got %0d want %0d", k, xfer_cnt, k);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (xfer_cnt !== 8'd5 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_done: got cnt=%0d valid=%b want 5/0", xfer_cnt, bus_valid);
        end
    endtask

    task automatic test_backpressure();
        // ptr is 1: requester 1 wins first, then the scan from 2 wraps to 0
        req       = 4'b0011;
        data_in   = 16'h0097;
        bus_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL bp_first_gnt: got %b want 0010", gnt);
        end
        tick();
        bus_ready = 1'b0;
        checks++;
        if (bus_data !== 4'h9 || bus_src !== 2'd1 || bus_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_first_lane: got data=%h src=%0d valid=%b want 9/1/1",
                     bus_data, bus_src, bus_valid);
        end
        for (int k = 0; k < 5; k++) begin
            data_in = 16'h0090 | 16'(k);
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                failures++;
                $display("FAIL bp_stall_gnt[%0d]: got %b want 0000", k, gnt);
            end
            tick();
            checks++;
            if (bus_data !== 4'h9 || bus_valid !== 1'b1 || xfer_cnt !== 8'd5) begin
                failures++;
                $display("FAIL bp_stall_hold[%0d]: got data=%h valid=%b cnt=%0d want 9/1/5",
                         k, bus_data, bus_valid, xfer_cnt);
            end
        end
        data_in   = 16'h0097;
        bus_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL bp_release_gnt: got %b want 0001", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (bus_data !== 4'h7 || bus_src !== 2'd0 || bus_valid !== 1'b1 || xfer_cnt !== 8'd6) begin
            failures++;
            $display("FAIL bp_release_lane: got data=%h src=%0d valid=%b cnt=%0d want 7/0/1/6",
                     bus_data, bus_src, bus_valid, xfer_cnt);
        end
        tick();
        checks++;
        if (xfer_cnt !== 8'd7 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: got cnt=%0d valid=%b want 7/0", xfer_cnt, bus_valid);
        end
    endtask

    task automatic test_ptr_wrap();
        int         exp_src [3] = '{0, 2, 0};
        logic [3:0] exp_dat [3] = '{4'hC, 4'hD, 4'hC};
        logic [3:0] exp_gnt;
        // ptr 1 -> grant requester 2 so ptr becomes 3
        req       = 4'b0100;
        data_in   = 16'h0E00;
        bus_ready = 1'b1;
        tick();
        req     = 4'b0101;
        data_in = 16'h0D0C;
        for (int k = 0; k < 3; k++) begin
            #1;
            exp_gnt = 4'b0001 << exp_src[k];
            checks++;
            if (gnt !== exp_gnt) begin
                failures++;
                $display("FAIL wrap_gnt[%0d]: got %b want %b", k, gnt, exp_gnt);
            end
            tick();
            checks++;
            if (32'(bus_src) != exp_src[k] || bus_data !== exp_dat[k] || 32'(xfer_cnt) != 8 + k) begin
                failures++;
                $display("FAIL wrap_lane[%0d]: got src=%0d data=%h cnt=%0d want %0d/%h/%0d",
                         k, bus_src, bus_data, xfer_cnt, exp_src[k], exp_dat[k], 8 + k);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (xfer_cnt !== 8'd11 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done: got cnt=%0d valid=%b want 11/0", xfer_cnt, bus_valid);
        end
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        req       = 4'b0001;
        data_in   = 16'h0003;
        bus_ready = 1'b1;
        repeat (256) tick();
        checks++;
        if (xfer_cnt !== 8'd255) begin
            failures++;
            $display("FAIL cnt_255: got %0d want 255", xfer_cnt);
        end
        tick();
        checks++;
        if (xfer_cnt !== 8'd0) begin
            failures++;
            $display("FAIL cnt_wrap0: got %0d want 0", xfer_cnt);
        end
        tick();
        checks++;
        if (xfer_cnt !== 8'd1) begin
            failures++;
            $display("FAIL cnt_wrap1: got %0d want 1", xfer_cnt);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req       = '0;
        data_in   = '0;
        bus_ready = 1'b0;
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_backpressure();
        test_ptr_wrap();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
